// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 power-up sequencer.
// Contents:
//   oled_init_state_t  sequencer state encoding
//   OLED_CMD_LEN       number of bytes in the init command list
//   OLED_GDDRAM_BYTES  bytes needed to clear the 128x64 display RAM
//   OLED_CMD_*         SSD1306 command opcodes used by the init list
package oled_pkg;

  typedef enum logic [2:0] {
    ST_RST_LO,
    ST_RST_WAIT,
    ST_CMD_SEND,
    ST_CMD_WAIT,
    ST_CLR_SEND,
    ST_CLR_WAIT,
    ST_DONE
  } oled_init_state_t;

  localparam int unsigned OLED_CMD_LEN      = 31;
  localparam int unsigned OLED_GDDRAM_BYTES = 1024;

  localparam logic [7:0] OLED_CMD_DISP_OFF     = 8'hAE;
  localparam logic [7:0] OLED_CMD_CLK_DIV      = 8'hD5;
  localparam logic [7:0] OLED_CMD_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] OLED_CMD_DISP_OFFSET  = 8'hD3;
  localparam logic [7:0] OLED_CMD_START_LINE   = 8'h40;
  localparam logic [7:0] OLED_CMD_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] OLED_CMD_ADDR_MODE    = 8'h20;
  localparam logic [7:0] OLED_CMD_SEG_REMAP    = 8'hA1;
  localparam logic [7:0] OLED_CMD_COM_SCAN_DEC = 8'hC8;
  localparam logic [7:0] OLED_CMD_COM_PINS     = 8'hDA;
  localparam logic [7:0] OLED_CMD_CONTRAST     = 8'h81;
  localparam logic [7:0] OLED_CMD_PRECHARGE    = 8'hD9;
  localparam logic [7:0] OLED_CMD_VCOMH        = 8'hDB;
  localparam logic [7:0] OLED_CMD_RESUME_RAM   = 8'hA4;
  localparam logic [7:0] OLED_CMD_NORMAL_DISP  = 8'hA6;
  localparam logic [7:0] OLED_CMD_COL_ADDR     = 8'h21;
  localparam logic [7:0] OLED_CMD_PAGE_ADDR    = 8'h22;
  localparam logic [7:0] OLED_CMD_DISP_ON      = 8'hAF;

endpackage

// File: rtl/oled_init_rom.sv
// Combinational command ROM holding the SSD1306 init list.
// Ports:
//   idx       in  5  command index (0..OLED_CMD_LEN-1)
//   cmd_byte  out 8  command byte at idx; 8'h00 past the end of the list
module oled_init_rom
  import oled_pkg::*;
(
  input  logic [4:0] idx,
  output logic [7:0] cmd_byte
);

  always_comb begin
    cmd_byte = 8'h00;
    case (idx)
      5'd0:  cmd_byte = OLED_CMD_DISP_OFF;
      5'd1:  cmd_byte = OLED_CMD_CLK_DIV;
      5'd2:  cmd_byte = 8'h80;
      5'd3:  cmd_byte = OLED_CMD_MUX_RATIO;
      5'd4:  cmd_byte = 8'h3F;
      5'd5:  cmd_byte = OLED_CMD_DISP_OFFSET;
      5'd6:  cmd_byte = 8'h00;
      5'd7:  cmd_byte = OLED_CMD_START_LINE;
      5'd8:  cmd_byte = OLED_CMD_CHARGE_PUMP;
      5'd9:  cmd_byte = 8'h14;
      5'd10: cmd_byte = OLED_CMD_ADDR_MODE;
      5'd11: cmd_byte = 8'h00;
      5'd12: cmd_byte = OLED_CMD_SEG_REMAP;
      5'd13: cmd_byte = OLED_CMD_COM_SCAN_DEC;
      5'd14: cmd_byte = OLED_CMD_COM_PINS;
      5'd15: cmd_byte = 8'h12;
      5'd16: cmd_byte = OLED_CMD_CONTRAST;
      5'd17: cmd_byte = 8'hCF;
      5'd18: cmd_byte = OLED_CMD_PRECHARGE;
      5'd19: cmd_byte = 8'hF1;
      5'd20: cmd_byte = OLED_CMD_VCOMH;
      5'd21: cmd_byte = 8'h40;
      5'd22: cmd_byte = OLED_CMD_RESUME_RAM;
      5'd23: cmd_byte = OLED_CMD_NORMAL_DISP;
      5'd24: cmd_byte = OLED_CMD_COL_ADDR;
      5'd25: cmd_byte = 8'h00;
      5'd26: cmd_byte = 8'h7F;
      5'd27: cmd_byte = OLED_CMD_PAGE_ADDR;
      5'd28: cmd_byte = 8'h00;
      5'd29: cmd_byte = 8'h07;
      5'd30: cmd_byte = OLED_CMD_DISP_ON;
      default: cmd_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/oled_init.sv
// SSD1306 128x64 power-up sequencer. Pulses the panel reset, waits for the
// panel to settle, then streams the init command list through the shared SPI
// byte writer and raises a sticky init_done.
// Optional feature: define OLED_INIT_CLEAR_EN to follow the command list with
// 1024 data bytes of 8'h00 that clear GDDRAM before init_done.
// Parameters:
//   RST_LOW_CYC   cycles oled_res is held low after reset release
//   RST_WAIT_CYC  cycles waited after oled_res rises, before the first byte
// Ports:
//   clk         in  1  system clock
//   rst_n       in  1  asynchronous active-low reset
//   write_done  in  1  SPI writer finished the current byte (1-cycle pulse)
//   oled_res    out 1  panel reset, active low
//   oled_dc     out 1  0 = command byte, 1 = data byte
//   ena_write   out 1  1-cycle start pulse to the SPI writer
//   data        out 8  byte to send, held until write_done
//   init_done   out 1  sticky high once the sequence completes
module oled_init
  import oled_pkg::*;
#(
  parameter int unsigned RST_LOW_CYC  = 500,
  parameter int unsigned RST_WAIT_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_done,
  output logic       oled_res,
  output logic       oled_dc,
  output logic       ena_write,
  output logic [7:0] data,
  output logic       init_done
);

  localparam int unsigned LO_W   = $clog2(RST_LOW_CYC + 1);
  localparam int unsigned WAIT_W = $clog2(RST_WAIT_CYC + 1);

  localparam logic [LO_W-1:0]   LO_LAST   = LO_W'(RST_LOW_CYC);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RST_WAIT_CYC - 1);
  localparam logic [4:0]        CMD_LAST  = 5'(OLED_CMD_LEN - 1);

  oled_init_state_t  state;
  logic [LO_W-1:0]   lo_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [4:0]        cmd_idx;
  logic [4:0]        rom_idx;
  logic [7:0]        rom_byte;

`ifdef OLED_INIT_CLEAR_EN
  localparam logic [9:0] CLR_LAST = 10'(OLED_GDDRAM_BYTES - 1);
  logic [9:0] clr_cnt;
`endif

  // The ROM is addressed with the index of the byte about to be launched, so
  // the next byte is registered on the same edge that accepts write_done and
  // the writer sees only one idle cycle between bytes.
  assign rom_idx = (state == ST_CMD_WAIT) ? cmd_idx + 5'd1 : '0;

  oled_init_rom u_rom (
    .idx      (rom_idx),
    .cmd_byte (rom_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST_LO;
      lo_cnt    <= '0;
      wait_cnt  <= '0;
      cmd_idx   <= '0;
      oled_res  <= 1'b0;
      oled_dc   <= 1'b0;
      ena_write <= 1'b0;
      data      <= '0;
      init_done <= 1'b0;
`ifdef OLED_INIT_CLEAR_EN
      clr_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_RST_LO: begin
          // Counts from the reset value so oled_res rises on the edge that
          // is RST_LOW_CYC cycles after release.
          if (lo_cnt == LO_LAST) begin
            lo_cnt   <= '0;
            oled_res <= 1'b1;
            state    <= ST_RST_WAIT;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end

        ST_RST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= '0;
            cmd_idx   <= '0;
            data      <= rom_byte;
            oled_dc   <= 1'b0;
            ena_write <= 1'b1;
            state     <= ST_CMD_SEND;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_CMD_SEND: begin
          ena_write <= 1'b0;
          state     <= ST_CMD_WAIT;
        end

        ST_CMD_WAIT: begin
          if (write_done) begin
            if (cmd_idx == CMD_LAST) begin
`ifdef OLED_INIT_CLEAR_EN
              clr_cnt   <= '0;
              data      <= '0;
              oled_dc   <= 1'b1;
              ena_write <= 1'b1;
              state     <= ST_CLR_SEND;
`else
              data      <= '0;
              oled_dc   <= 1'b0;
              init_done <= 1'b1;
              state     <= ST_DONE;
`endif
            end else begin
              cmd_idx   <= cmd_idx + 5'd1;
              data      <= rom_byte;
              oled_dc   <= 1'b0;
              ena_write <= 1'b1;
              state     <= ST_CMD_SEND;
            end
          end
        end

`ifdef OLED_INIT_CLEAR_EN
        ST_CLR_SEND: begin
          ena_write <= 1'b0;
          state     <= ST_CLR_WAIT;
        end

        ST_CLR_WAIT: begin
          if (write_done) begin
            if (clr_cnt == CLR_LAST) begin
              clr_cnt   <= '0;
              data      <= '0;
              oled_dc   <= 1'b0;
              init_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              clr_cnt   <= clr_cnt + 10'd1;
              ena_write <= 1'b1;
              state     <= ST_CLR_SEND;
            end
          end
        end
`endif

        ST_DONE: begin
          oled_res  <= 1'b1;
          oled_dc   <= 1'b0;
          ena_write <= 1'b0;
          data      <= '0;
          init_done <= 1'b1;
        end

        default: begin
          state <= ST_RST_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_init.sv
// Directed bench for oled_init with RST_LOW_CYC=4, RST_WAIT_CYC=8 and an SPI
// writer model that pulses write_done 16 cycles after each ena_write.
module tb_oled_init;

`ifdef OLED_INIT_CLEAR_EN
  localparam int EXP_TOTAL = 1055;
`else
  localparam int EXP_TOTAL = 31;
`endif

  logic       clk;
  logic       rst_n;
  logic       write_done;
  logic       oled_res;
  logic       oled_dc;
  logic       ena_write;
  logic [7:0] data;
  logic       init_done;

  oled_init #(
    .RST_LOW_CYC  (4),
    .RST_WAIT_CYC (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_done (write_done),
    .oled_res   (oled_res),
    .oled_dc    (oled_dc),
    .ena_write  (ena_write),
    .data       (data),
    .init_done  (init_done)
  );

  logic [7:0] exp_cmd [31] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
    8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF
  };

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = -1;
  bit         spur = 1'b0;
  logic [7:0] log_data [$];
  logic       log_dc [$];
  int         last_wd_cyc = -1;
  int         init_rise_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: 0 is the first rising edge with rst_n high.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) cyc = -1;
      else        cyc = cyc + 1;
    end
  end

  // SPI writer model, driven just after each rising edge.
  initial begin
    bit busy;
    int cd;
    busy = 1'b0;
    cd = 0;
    write_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      write_done = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cd = cd - 1;
          if (cd == 0) begin
            write_done = 1'b1;
            busy = 1'b0;
          end
        end
        if (ena_write) begin
          busy = 1'b1;
          cd = 16;
        end
      end
      if (spur) begin
        write_done = 1'b1;
        spur = 1'b0;
      end
    end
  end

  // Byte logger and protocol monitor, sampling on the falling edge.
  initial begin
    bit         out;
    logic [7:0] held_data;
    logic       held_dc;
    logic       prev_init;
    out = 1'b0;
    held_data = '0;
    held_dc = 1'b0;
    prev_init = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out = 1'b0;
        prev_init = 1'b0;
      end else begin
        if (out && write_done) begin
          out = 1'b0;
          last_wd_cyc = cyc;
        end
        if (ena_write) begin
          check("ena_while_busy", 32'(out), 32'd0);
          out = 1'b1;
          held_data = data;
          held_dc = oled_dc;
          log_data.push_back(data);
          log_dc.push_back(oled_dc);
        end else if (out) begin
          check("hold_data", 32'(data), 32'(held_data));
          check("hold_dc", 32'(oled_dc), 32'(held_dc));
        end
        if (init_done && !prev_init) init_rise_cyc = cyc;
        if (prev_init) check("init_sticky", 32'(init_done), 32'd1);
        prev_init = init_done;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_res"},  32'(oled_res),  32'd0);
    check({tag, "_dc"},   32'(oled_dc),   32'd0);
    check({tag, "_ena"},  32'(ena_write), 32'd0);
    check({tag, "_data"}, 32'(data),      32'd0);
    check({tag, "_init"}, 32'(init_done), 32'd0);
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < 25000 && !init_done; i++) @(negedge clk);
    check(tag, 32'(init_done), 32'd1);
  endtask

  task automatic verify_log(input string tag);
    int n;
    n = log_data.size();
    check({tag, "_count"}, 32'(n), 32'(EXP_TOTAL));
    for (int i = 0; i < n && i < EXP_TOTAL; i++) begin
      if (i < 31) begin
        check({tag, "_cmd"}, 32'(log_data[i]), 32'(exp_cmd[i]));
        check({tag, "_cmd_dc"}, 32'(log_dc[i]), 32'd0);
      end else begin
        check({tag, "_clr"}, 32'(log_data[i]), 32'd0);
        check({tag, "_clr_dc"}, 32'(log_dc[i]), 32'd1);
      end
    end
    check({tag, "_init_rise"}, 32'(init_rise_cyc), 32'(last_wd_cyc + 1));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    log_data.delete();
    log_dc.delete();
    rst_n = 1'b1;

    // Reset pulse timing and first byte, with a spurious write_done in RST_WAIT.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("cyc_index", 32'(cyc), 32'(k));
      check("res_timing", 32'(oled_res), (k >= 4) ? 32'd1 : 32'd0);
      check("ena_timing", 32'(ena_write), (k == 12) ? 32'd1 : 32'd0);
      if (k == 6) spur = 1'b1;
      if (k == 12) begin
        check("first_data", 32'(data), 32'hAE);
        check("first_dc", 32'(oled_dc), 32'd0);
      end
    end

    wait_init("run1_done");
    repeat (2) @(negedge clk);
    verify_log("run1");

    // Spurious write_done while DONE.
    spur = 1'b1;
    repeat (5) @(negedge clk);
    check("done_ena", 32'(ena_write), 32'd0);
    check("done_init", 32'(init_done), 32'd1);
    check("done_res", 32'(oled_res), 32'd1);
    check("done_data", 32'(data), 32'd0);
    check("done_dc", 32'(oled_dc), 32'd0);
    check("done_no_extra", 32'(log_data.size()), 32'(EXP_TOTAL));

    // Reset asserted during the 10th command byte.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    log_data.delete();
    log_dc.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 2000 && log_data.size() < 10; i++) @(negedge clk);
    check("reach_10th", 32'(log_data.size() >= 10), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    log_data.delete();
    log_dc.delete();
    init_rise_cyc = -1;
    rst_n = 1'b1;
    wait_init("run2_done");
    repeat (2) @(negedge clk);
    verify_log("run2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
